// File: rtl/layer_desc_decoder.sv
// Layer-descriptor decoder: latches one descriptor, derives padded/output dims, tile
// sizes/counts and a GLB-limited spatial tile length with a shared serial divider.
module layer_desc_decoder #(
  parameter int GLB_BYTES = 65536,
  parameter int BYTES_I   = 1,
  parameter int BYTES_W   = 1,
  parameter int BYTES_P   = 2,
  parameter int DIM_W     = 8,
  parameter int CH_W      = 11,
  parameter int KW_W      = 3,
  parameter int DIV_W     = 32,
  parameter int TILE_PW   = 32,
  parameter int TILE_DW   = 10,
  parameter int TILE_STD  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [1:0]        layer_type_i,
  input  logic [DIM_W-1:0]  in_R_i,
  input  logic [DIM_W-1:0]  in_C_i,
  input  logic [CH_W-1:0]   in_D_i,
  input  logic [CH_W-1:0]   out_K_i,
  input  logic [KW_W-1:0]   kH_i,
  input  logic [KW_W-1:0]   kW_i,
  input  logic [1:0]        stride_i,
  input  logic [1:0]        pad_T_i,
  input  logic [1:0]        pad_B_i,
  input  logic [1:0]        pad_L_i,
  input  logic [1:0]        pad_R_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DIM_W+1:0]  padded_R_o,
  output logic [DIM_W+1:0]  padded_C_o,
  output logic [DIM_W-1:0]  out_R_o,
  output logic [DIM_W-1:0]  out_C_o,
  output logic [6:0]        tile_D_o,
  output logic [6:0]        tile_K_o,
  output logic [CH_W-1:0]   num_tiles_D_o,
  output logic [CH_W-1:0]   num_tiles_K_o,
  output logic [DIV_W-1:0]  tile_n_o,
  output logic [2:0]        err_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  function automatic logic [6:0] tile_size(input logic [1:0] t);
    case (t)
      2'd1:    return 7'(TILE_DW);
      2'd2:    return 7'(TILE_STD);
      default: return 7'(TILE_PW);
    endcase
  endfunction

  // Depthwise weights only span one input channel per filter.
  function automatic logic [6:0] tile_d_filt(input logic [1:0] t);
    case (t)
      2'd1:    return 7'd1;
      2'd2:    return 7'(TILE_STD);
      default: return 7'(TILE_PW);
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         type_q, type_d;
  logic [DIM_W-1:0]   in_r_q, in_r_d, in_c_q, in_c_d;
  logic [CH_W-1:0]    in_d_q, in_d_d, out_k_q, out_k_d;
  logic [KW_W-1:0]    kh_q, kh_d, kw_q, kw_d;
  logic [1:0]         stride_q, stride_d;
  logic [1:0]         pad_t_q, pad_t_d, pad_b_q, pad_b_d;
  logic [1:0]         pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [DIV_W-1:0]   glb_num_q, glb_num_d, tmp2_q, tmp2_d;
  logic [DIM_W+1:0]   padded_r_q, padded_r_d, padded_c_q, padded_c_d;
  logic [DIM_W-1:0]   out_r_q, out_r_d, out_c_q, out_c_d;
  logic [6:0]         tile_d_q, tile_d_d, tile_k_q, tile_k_d;
  logic [CH_W-1:0]    ntd_q, ntd_d, ntk_q, ntk_d;
  logic [DIV_W-1:0]   tile_n_q, tile_n_d;
  logic [2:0]         err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [DIV_W-1:0]   rem_q, rem_d;
  logic [DIV_W-2:0]   quo_q, quo_d;

  logic [DIM_W+1:0]   padded_r_c, padded_c_c;
  logic [DIV_W-1:0]   tmp1_c, tmp2_c;
  logic [2:0]         err_c;
  logic [DIV_W-1:0]   num_c, den_c;
  logic [CNT_W-1:0]   bit_idx;
  logic [DIV_W:0]     rem_sh;
  logic               qbit;
  logic [DIV_W-1:0]   q_full;
  logic               force_1x1;

  assign force_1x1 = (layer_type_i == 2'd0) || (layer_type_i == 2'd3);

  always_comb begin
    padded_r_c = (DIM_W+2)'(in_r_q) + (DIM_W+2)'(pad_t_q) + (DIM_W+2)'(pad_b_q);
    padded_c_c = (DIM_W+2)'(in_c_q) + (DIM_W+2)'(pad_l_q) + (DIM_W+2)'(pad_r_q);
    tmp1_c = DIV_W'(kh_q) * DIV_W'(kw_q) * DIV_W'(tile_d_filt(type_q))
           * DIV_W'(tile_size(type_q)) * DIV_W'(BYTES_W);
    tmp2_c = DIV_W'(tile_size(type_q)) * DIV_W'(BYTES_I)
           + DIV_W'(tile_size(type_q)) * DIV_W'(BYTES_P);
    err_c[0] = (stride_q == 2'd0);
    err_c[1] = (padded_r_c < (DIM_W+2)'(kh_q)) || (padded_c_c < (DIM_W+2)'(kw_q));
    err_c[2] = (tmp1_c >= DIV_W'(GLB_BYTES));
  end

  // Divider operand select: ceil-divides are folded in as (a + b - 1) / b.
  always_comb begin
    num_c = glb_num_q;
    den_c = tmp2_q;
    case (op_q)
      3'd0: begin
        num_c = DIV_W'(padded_r_q) - DIV_W'(kh_q);
        den_c = DIV_W'(stride_q);
      end
      3'd1: begin
        num_c = DIV_W'(padded_c_q) - DIV_W'(kw_q);
        den_c = DIV_W'(stride_q);
      end
      3'd2: begin
        num_c = DIV_W'(in_d_q) + DIV_W'(tile_d_q) - DIV_W'(1);
        den_c = DIV_W'(tile_d_q);
      end
      3'd3: begin
        num_c = DIV_W'(out_k_q) + DIV_W'(tile_k_q) - DIV_W'(1);
        den_c = DIV_W'(tile_k_q);
      end
      default: ;
    endcase
    bit_idx = CNT_W'(DIV_W - 1) - cnt_q;
    rem_sh  = {rem_q, num_c[bit_idx]};
    qbit    = (rem_sh >= {1'b0, den_c});
    q_full  = {quo_q, qbit};
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    in_r_d     = in_r_q;
    in_c_d     = in_c_q;
    in_d_d     = in_d_q;
    out_k_d    = out_k_q;
    kh_d       = kh_q;
    kw_d       = kw_q;
    stride_d   = stride_q;
    pad_t_d    = pad_t_q;
    pad_b_d    = pad_b_q;
    pad_l_d    = pad_l_q;
    pad_r_d    = pad_r_q;
    glb_num_d  = glb_num_q;
    tmp2_d     = tmp2_q;
    padded_r_d = padded_r_q;
    padded_c_d = padded_c_q;
    out_r_d    = out_r_q;
    out_c_d    = out_c_q;
    tile_d_d   = tile_d_q;
    tile_k_d   = tile_k_q;
    ntd_d      = ntd_q;
    ntk_d      = ntk_q;
    tile_n_d   = tile_n_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rem_d      = rem_q;
    quo_d      = quo_q;

    case (state_q)
      IDLE: begin
        if (desc_valid_i) begin
          type_d   = layer_type_i;
          in_r_d   = in_R_i;
          in_c_d   = in_C_i;
          in_d_d   = in_D_i;
          out_k_d  = out_K_i;
          kh_d     = force_1x1 ? KW_W'(1) : kH_i;
          kw_d     = force_1x1 ? KW_W'(1) : kW_i;
          stride_d = stride_i;
          pad_t_d  = pad_T_i;
          pad_b_d  = pad_B_i;
          pad_l_d  = pad_L_i;
          pad_r_d  = pad_R_i;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        tile_d_d = tile_size(type_q);
        tile_k_d = tile_size(type_q);
        err_d    = err_c;
        out_r_d  = '0;
        out_c_d  = '0;
        ntd_d    = '0;
        ntk_d    = '0;
        tile_n_d = '0;
        if (err_c != 3'd0) begin
          padded_r_d = '0;
          padded_c_d = '0;
          state_d    = DONE;
        end else begin
          padded_r_d = padded_r_c;
          padded_c_d = padded_c_c;
          glb_num_d  = DIV_W'(GLB_BYTES) - tmp1_c;
          tmp2_d     = tmp2_c;
          cnt_d      = '0;
          op_d       = '0;
          rem_d      = '0;
          quo_d      = '0;
          state_d    = DIV;
        end
      end
      DIV: begin
        rem_d = qbit ? DIV_W'(rem_sh - {1'b0, den_c}) : rem_sh[DIV_W-1:0];
        quo_d = q_full[DIV_W-2:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV_W - 1)) begin
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          op_d  = op_q + 3'd1;
          case (op_q)
            3'd0: out_r_d = DIM_W'(q_full + DIV_W'(1));
            3'd1: out_c_d = DIM_W'(q_full + DIV_W'(1));
            3'd2: ntd_d   = CH_W'(q_full);
            3'd3: ntk_d   = CH_W'(q_full);
            default: begin
              tile_n_d = {q_full[DIV_W-1:2], 2'b00};
              state_d  = DONE;
            end
          endcase
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      type_q     <= '0;
      in_r_q     <= '0;
      in_c_q     <= '0;
      in_d_q     <= '0;
      out_k_q    <= '0;
      kh_q       <= '0;
      kw_q       <= '0;
      stride_q   <= '0;
      pad_t_q    <= '0;
      pad_b_q    <= '0;
      pad_l_q    <= '0;
      pad_r_q    <= '0;
      glb_num_q  <= '0;
      tmp2_q     <= '0;
      padded_r_q <= '0;
      padded_c_q <= '0;
      out_r_q    <= '0;
      out_c_q    <= '0;
      tile_d_q   <= '0;
      tile_k_q   <= '0;
      ntd_q      <= '0;
      ntk_q      <= '0;
      tile_n_q   <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      in_r_q     <= in_r_d;
      in_c_q     <= in_c_d;
      in_d_q     <= in_d_d;
      out_k_q    <= out_k_d;
      kh_q       <= kh_d;
      kw_q       <= kw_d;
      stride_q   <= stride_d;
      pad_t_q    <= pad_t_d;
      pad_b_q    <= pad_b_d;
      pad_l_q    <= pad_l_d;
      pad_r_q    <= pad_r_d;
      glb_num_q  <= glb_num_d;
      tmp2_q     <= tmp2_d;
      padded_r_q <= padded_r_d;
      padded_c_q <= padded_c_d;
      out_r_q    <= out_r_d;
      out_c_q    <= out_c_d;
      tile_d_q   <= tile_d_d;
      tile_k_q   <= tile_k_d;
      ntd_q      <= ntd_d;
      ntk_q      <= ntk_d;
      tile_n_q   <= tile_n_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
    end
  end

  assign desc_ready_o  = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign out_valid_o   = (state_q == DONE);
  assign padded_R_o    = padded_r_q;
  assign padded_C_o    = padded_c_q;
  assign out_R_o       = out_r_q;
  assign out_C_o       = out_c_q;
  assign tile_D_o      = tile_d_q;
  assign tile_K_o      = tile_k_q;
  assign num_tiles_D_o = ntd_q;
  assign num_tiles_K_o = ntk_q;
  assign tile_n_o      = tile_n_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_layer_desc_decoder.sv
// Randomized and directed bench for layer_desc_decoder against an arithmetic reference model.
module tb_layer_desc_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_valid_i, desc_ready_o;
  logic [1:0]  layer_type_i;
  logic [7:0]  in_R_i, in_C_i;
  logic [10:0] in_D_i, out_K_i;
  logic [2:0]  kH_i, kW_i;
  logic [1:0]  stride_i, pad_T_i, pad_B_i, pad_L_i, pad_R_i;
  logic        out_valid_o, out_ready_i;
  logic [9:0]  padded_R_o, padded_C_o;
  logic [7:0]  out_R_o, out_C_o;
  logic [6:0]  tile_D_o, tile_K_o;
  logic [10:0] num_tiles_D_o, num_tiles_K_o;
  logic [31:0] tile_n_o;
  logic [2:0]  err_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  // current descriptor
  int d_type, d_r, d_c, d_d, d_k, d_kh, d_kw, d_s, d_pt, d_pb, d_pl, d_pr;
  // expected result
  int e_pr, e_pc, e_or, e_oc, e_td, e_tk, e_nd, e_nk, e_err, e_lat;
  longint e_tn;

  always #5 clk = ~clk;

  layer_desc_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .layer_type_i(layer_type_i), .in_R_i(in_R_i), .in_C_i(in_C_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .kH_i(kH_i), .kW_i(kW_i),
    .stride_i(stride_i), .pad_T_i(pad_T_i), .pad_B_i(pad_B_i),
    .pad_L_i(pad_L_i), .pad_R_i(pad_R_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .padded_R_o(padded_R_o), .padded_C_o(padded_C_o),
    .out_R_o(out_R_o), .out_C_o(out_C_o),
    .tile_D_o(tile_D_o), .tile_K_o(tile_K_o),
    .num_tiles_D_o(num_tiles_D_o), .num_tiles_K_o(num_tiles_K_o),
    .tile_n_o(tile_n_o), .err_o(err_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void set_desc(int t, int r, int c, int d, int k, int kh, int kw,
                                   int s, int pt, int pb, int pl, int pr);
    d_type = t; d_r = r; d_c = c; d_d = d; d_k = k; d_kh = kh; d_kw = kw;
    d_s = s; d_pt = pt; d_pb = pb; d_pl = pl; d_pr = pr;
  endfunction

  // Reference: straight arithmetic from the layer-type rules.
  function automatic void model();
    int kh, kw, tdf;
    longint tmp1, tmp2;
    bit pw_like;
    pw_like = (d_type == 0) || (d_type == 3);
    kh = pw_like ? 1 : d_kh;
    kw = pw_like ? 1 : d_kw;
    e_td = pw_like ? 32 : 10;
    e_tk = e_td;
    tdf  = (d_type == 1) ? 1 : e_td;
    tmp1 = longint'(kh) * kw * tdf * e_tk * 1;
    tmp2 = longint'(e_td) * 1 + longint'(e_tk) * 2;
    e_pr = d_r + d_pt + d_pb;
    e_pc = d_c + d_pl + d_pr;
    e_err = 0;
    if (d_s == 0) e_err |= 1;
    if (e_pr < kh || e_pc < kw) e_err |= 2;
    if (tmp1 >= 65536) e_err |= 4;
    if (e_err != 0) begin
      e_pr = 0; e_pc = 0; e_or = 0; e_oc = 0; e_nd = 0; e_nk = 0; e_tn = 0;
      e_lat = 1;
    end else begin
      e_or = ((e_pr - kh) / d_s + 1) % 256;
      e_oc = ((e_pc - kw) / d_s + 1) % 256;
      e_nd = ((d_d + e_td - 1) / e_td) % 2048;
      e_nk = ((d_k + e_tk - 1) / e_tk) % 2048;
      e_tn = ((65536 - tmp1) / tmp2) / 4 * 4;
      e_lat = 1 + 5 * 32;
    end
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, ".valid"},  64'(out_valid_o), 64'(1));
    chk({pfx, ".err"},    64'(err_o), 64'(e_err));
    chk({pfx, ".padR"},   64'(padded_R_o), 64'(e_pr));
    chk({pfx, ".padC"},   64'(padded_C_o), 64'(e_pc));
    chk({pfx, ".outR"},   64'(out_R_o), 64'(e_or));
    chk({pfx, ".outC"},   64'(out_C_o), 64'(e_oc));
    chk({pfx, ".tileD"},  64'(tile_D_o), 64'(e_td));
    chk({pfx, ".tileK"},  64'(tile_K_o), 64'(e_tk));
    chk({pfx, ".ntD"},    64'(num_tiles_D_o), 64'(e_nd));
    chk({pfx, ".ntK"},    64'(num_tiles_K_o), 64'(e_nk));
    chk({pfx, ".tileN"},  64'(tile_n_o), 64'(e_tn));
  endtask

  task automatic scramble_inputs();
    layer_type_i = 2'($urandom); in_R_i = 8'($urandom); in_C_i = 8'($urandom);
    in_D_i = 11'($urandom); out_K_i = 11'($urandom); kH_i = 3'($urandom);
    kW_i = 3'($urandom); stride_i = 2'($urandom); pad_T_i = 2'($urandom);
    pad_B_i = 2'($urandom); pad_L_i = 2'($urandom); pad_R_i = 2'($urandom);
  endtask

  task automatic accept_desc(input string pfx);
    @(negedge clk);
    layer_type_i = 2'(d_type); in_R_i = 8'(d_r); in_C_i = 8'(d_c);
    in_D_i = 11'(d_d); out_K_i = 11'(d_k); kH_i = 3'(d_kh); kW_i = 3'(d_kw);
    stride_i = 2'(d_s); pad_T_i = 2'(d_pt); pad_B_i = 2'(d_pb);
    pad_L_i = 2'(d_pl); pad_R_i = 2'(d_pr);
    desc_valid_i = 1'b1;
    chk({pfx, ".ready"}, 64'(desc_ready_o), 64'(1));
    @(posedge clk);
    #1;
    desc_valid_i = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_desc(input string pfx, input int hold);
    int lat;
    model();
    accept_desc(pfx);
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_o) break;
    end
    chk({pfx, ".latency"}, 64'(lat), 64'(e_lat));
    check_outputs(pfx);
    for (int i = 0; i < hold; i++) begin
      desc_valid_i = 1'b1;
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
      chk({pfx, ".hold_ready"}, 64'(desc_ready_o), 64'(0));
      check_outputs({pfx, ".hold"});
    end
    desc_valid_i = 1'b0;
    out_ready_i  = 1'b1;
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    chk({pfx, ".post_valid"}, 64'(out_valid_o), 64'(0));
    chk({pfx, ".post_ready"}, 64'(desc_ready_o), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    desc_valid_i = 1'b0;
    out_ready_i  = 1'b0;
    scramble_inputs();
    #2;
    chk("rst.ready", 64'(desc_ready_o), 64'(1));
    chk("rst.valid", 64'(out_valid_o), 64'(0));
    chk("rst.busy",  64'(busy_o), 64'(0));
    chk("rst.tileN", 64'(tile_n_o), 64'(0));
    chk("rst.err",   64'(err_o), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    set_desc(0, 56, 56, 64, 128, 3, 3, 1, 0, 0, 0, 0);
    run_desc("pw", 0);
    set_desc(1, 112, 112, 32, 32, 3, 3, 2, 1, 1, 1, 1);
    run_desc("dw", 0);
    set_desc(0, 56, 56, 64, 128, 1, 1, 0, 0, 0, 0, 0);
    run_desc("stride0", 0);
    set_desc(2, 2, 10, 16, 16, 5, 3, 1, 0, 0, 0, 0);
    run_desc("std_small", 0);
    set_desc(2, 30, 20, 0, 0, 3, 3, 3, 1, 0, 2, 1);
    run_desc("zero_ch_s3", 0);
    set_desc(3, 255, 255, 2047, 2047, 7, 7, 1, 3, 3, 3, 3);
    run_desc("lin_max", 10);

    // asynchronous reset 50 cycles into the divide phase
    set_desc(0, 56, 56, 64, 128, 3, 3, 1, 0, 0, 0, 0);
    accept_desc("rst_mid");
    repeat (51) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.valid", 64'(out_valid_o), 64'(0));
    chk("rst_mid.busy",  64'(busy_o), 64'(0));
    chk("rst_mid.ready", 64'(desc_ready_o), 64'(1));
    chk("rst_mid.padR",  64'(padded_R_o), 64'(0));
    chk("rst_mid.tileD", 64'(tile_D_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_desc("pw_again", 0);

    for (int n = 0; n < 25; n++) begin
      set_desc(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 2047)),
               int'($urandom_range(0, 2047)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_desc($sformatf("rnd%0d", n), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
